// File: rtl/ysyx_040066_mem_pkg.sv
// Shared types and constants for the memory-side responder.
package ysyx_040066_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    XFER,
    RESP,
    ERR,
    DONE
  } state_e;

  // Values double as bit positions in the arbiter's one-hot grant vector.
  typedef enum logic [1:0] {
    WR  = 2'd0,
    RD  = 2'd1,
    INS = 2'd2
  } port_e;

  localparam int BEATS      = 8;
  localparam int LINE_BYTES = 64;

  // Bursts start at the line base, single accesses at the dword base.
  function automatic logic [63:0] align_addr(input logic [63:0] addr, input logic burst);
    return burst ? (addr & ~64'(LINE_BYTES - 1)) : (addr & ~64'h7);
  endfunction

endpackage

// File: rtl/ysyx_040066_mem_arb.sv
// Fixed-priority grant among the three cache ports: wr > rd > ins.
module ysyx_040066_mem_arb
  import ysyx_040066_mem_pkg::*;
(
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       ins_req,
  output logic [2:0] grant,
  output logic       valid
);

  // Highest-priority active request wins; grant is one-hot indexed by port_e.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    grant = 3'b000;
    if (wr_req)       grant[WR]  = 1'b1;
    else if (rd_req)  grant[RD]  = 1'b1;
    else if (ins_req) grant[INS] = 1'b1;
  end

  assign valid = |grant;

endmodule

// File: rtl/ysyx_040066_mem_slave.sv
// Memory-side responder: arbitrates ins/rd/wr cache ports onto one 64-bit SRAM,
// serving 8-beat line bursts or single-dword accesses.
module ysyx_040066_mem_slave
  import ysyx_040066_mem_pkg::*;
#(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          WORDS   = 65536,
  parameter int          LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     ins_req,
  input  logic                     ins_burst,
  input  logic [63:0]              ins_addr,
  output logic                     ins_ready,
  output logic                     ins_last,
  output logic                     ins_err,
  output logic [63:0]              ins_data,

  input  logic                     rd_req,
  input  logic                     rd_burst,
  input  logic [2:0]               rd_len,
  input  logic [63:0]              rd_addr,
  output logic                     rd_ready,
  output logic                     rd_last,
  output logic                     rd_err,
  output logic [63:0]              rd_data,

  input  logic                     wr_req,
  input  logic                     wr_burst,
  input  logic [2:0]               wr_len,
  input  logic [7:0]               wr_mask,
  input  logic [63:0]              wr_addr,
  input  logic [511:0]             wr_data,
  output logic                     wr_ready,
  output logic                     wr_err,

  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(WORDS)-1:0] mem_addr,
  output logic [63:0]              mem_wdata,
  output logic [7:0]               mem_wmask,
  input  logic [63:0]              mem_rdata
);

  localparam int          AW    = $clog2(WORDS);
  localparam logic [63:0] LIMIT = BASE + 64'(WORDS) * 64'd8;
  localparam logic [3:0]  LAT_W = 4'(LATENCY);

  state_e         state, state_nx;
  port_e          port_q, sel_port;
  logic           burst_q, sel_burst;
  logic [63:0]    addr_q, sel_addr;
  logic [7:0]     mask_q;
  logic [511:0]   wdata_q;
  logic [3:0]     lat_cnt;
  logic [2:0]     beat_cnt;
  logic [2:0]     last_beat;
  logic [2:0]     grant;
  logic           grant_valid;
  logic           take;
  logic           in_range;
  logic [63:0]    word_off;
  logic           is_read;
  logic           beat_out;
  logic           err_out;
  logic           fin_out;
  logic           unused_ok;

  ysyx_040066_mem_arb u_arb (
    .wr_req  (wr_req),
    .rd_req  (rd_req),
    .ins_req (ins_req),
    .grant   (grant),
    .valid   (grant_valid)
  );

  assign take      = (state == IDLE) && grant_valid;
  assign last_beat = burst_q ? 3'(BEATS - 1) : 3'd0;
  assign in_range  = (addr_q >= BASE) && (addr_q < LIMIT);
  assign word_off  = (addr_q - BASE) >> 3;

  // Pick the granted port's request attributes.
  always_comb begin
    sel_port  = WR;
    sel_burst = wr_burst;
    sel_addr  = wr_addr;
    if (grant[RD]) begin
      sel_port  = RD;
      sel_burst = rd_burst;
      sel_addr  = rd_addr;
    end else if (grant[INS]) begin
      sel_port  = INS;
      sel_burst = ins_burst;
      sel_addr  = ins_addr;
    end
  end

  // Next-state logic: WAIT holds LATENCY+1 cycles so the first access lands at E+1+LATENCY.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (grant_valid) state_nx = WAIT;
      WAIT:      if (lat_cnt == LAT_W) state_nx = in_range ? XFER : ERR;
      XFER:      if (beat_cnt == last_beat) state_nx = RESP;
      RESP, ERR: state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // State, counters and transaction control bits, cleared by synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      port_q   <= WR;
      burst_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      lat_cnt  <= (state == WAIT) ? lat_cnt + 4'd1 : '0;
      beat_cnt <= (state == XFER) ? beat_cnt + 3'd1 : '0;
      if (take) begin
        port_q  <= sel_port;
        burst_q <= sel_burst;
      end
    end
  end

  // Request payload captured on grant; only read while a transaction is active.
  // NOTE: wide payload registers carry no reset; they are always written before being used.
  always_ff @(posedge clk) begin
    if (take) begin
      addr_q  <= align_addr(sel_addr, sel_burst);
      mask_q  <= wr_mask;
      wdata_q <= wr_data;
    end
  end

  // SRAM port and per-port responses, decoded from state; idle ports stay at 0.
  always_comb begin
    is_read   = (port_q != WR);
    beat_out  = is_read && (((state == XFER) && (beat_cnt != 3'd0)) || (state == RESP));
    err_out   = (state == ERR);
    fin_out   = (state == RESP) || err_out;

    mem_en    = (state == XFER);
    mem_we    = mem_en && (port_q == WR);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (mem_en) mem_addr = word_off[AW-1:0] + AW'(beat_cnt);
    if (mem_we) begin
      mem_wdata = wdata_q[{beat_cnt, 6'd0} +: 64];
      mem_wmask = burst_q ? 8'hFF : mask_q;
    end

    ins_ready = (port_q == INS) && (beat_out || err_out);
    ins_last  = (port_q == INS) && fin_out;
    ins_err   = (port_q == INS) && err_out;
    ins_data  = ((port_q == INS) && beat_out) ? mem_rdata : '0;

    rd_ready  = (port_q == RD) && (beat_out || err_out);
    rd_last   = (port_q == RD) && fin_out;
    rd_err    = (port_q == RD) && err_out;
    rd_data   = ((port_q == RD) && beat_out) ? mem_rdata : '0;

    wr_ready  = (port_q == WR) && fin_out;
    wr_err    = (port_q == WR) && err_out;
  end

  // Length fields are informational; high offset bits fall outside the SRAM.
  assign unused_ok = ^{rd_len, wr_len, word_off[63:AW]};

endmodule
